sqrt_arbiter: RTL

- Shares one 8-bit unsigned integer square-root core (4-bit root, bit-serial, one result bit per clock) between NUM_REQ requesters.
- The core is instantiated inside this block.
- Round-robin arbitration, valid/ready handshakes on request and response sides, one operation in flight.
- Sequences the core: holds it in reset, launches it, counts its fixed latency and captures the result.

---
 rtl/sqrt_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one bit-serial 8-bit integer square-root core between NUM_REQ requesters.
// Optional remainder output rsp_rem_o when SQRT_ARB_REMAINDER_EN is defined.

module sqrt_arbiter_core (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic [7:0] x_i,
  output logic [3:0] root_o
);
  logic [3:0] root_q, root_d;
  logic [3:0] bit_q, bit_d;
  logic [3:0] trial;
  logic [7:0] trial_sq;

  // One root bit per clock, MSB first: keep the trial bit if its square still fits.
  always_comb begin
    trial    = root_q | bit_q;
    trial_sq = {4'b0, trial} * {4'b0, trial};
    root_d   = root_q;
    bit_d    = bit_q;
    if (clr_i) begin
      root_d = '0;
      bit_d  = 4'b1000;
    end else if (bit_q != 4'b0) begin
      if (trial_sq <= x_i) root_d = trial;
      bit_d = bit_q >> 1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      root_q <= '0;
      bit_q  <= 4'b1000;
    end else begin
      root_q <= root_d;
      bit_q  <= bit_d;
    end
  end

  assign root_o = root_q;
endmodule

module sqrt_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int CORE_LATENCY = 4,
  parameter int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  logic [8*NUM_REQ-1:0] req_x_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [3:0]           rsp_result_o,
  output logic [ID_W-1:0]      rsp_id_o,
`ifdef SQRT_ARB_REMAINDER_EN
  output logic [4:0]           rsp_rem_o,
`endif
  output logic                 busy_o
);
  localparam int CNT_W = $clog2(CORE_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, CAPTURE, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [7:0]        x_q, x_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [3:0]        rsp_result_q, rsp_result_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
`ifdef SQRT_ARB_REMAINDER_EN
  logic [4:0]        rsp_rem_q, rsp_rem_d;
`endif

  logic              grant_vld;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W:0]     cand;
  logic              core_clr;
  logic [3:0]        core_root;

  // The core only runs in RUN; everywhere else it sits cleared, ready for the next operand.
  assign core_clr = (state_q != RUN);

  sqrt_arbiter_core u_core (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .clr_i  (core_clr),
    .x_i    (x_q),
    .root_o (core_root)
  );

  // First valid requester strictly after the round-robin pointer, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, rr_q} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!grant_vld && req_valid_i[cand[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (state_q == IDLE && grant_vld && rst_i) req_ready_o[grant_id] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    id_d         = id_q;
    x_d          = x_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_id_d     = rsp_id_q;
`ifdef SQRT_ARB_REMAINDER_EN
    rsp_rem_d    = rsp_rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          x_d     = req_x_i[grant_id*8 +: 8];
          id_d    = grant_id;
          rr_d    = grant_id;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(CORE_LATENCY - 1)) state_d = CAPTURE;
      end
      CAPTURE: begin
        rsp_result_d = core_root;
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
`ifdef SQRT_ARB_REMAINDER_EN
        rsp_rem_d    = 5'(x_q - {4'b0, core_root} * {4'b0, core_root});
`endif
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      rr_q         <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      x_q          <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_id_q     <= '0;
`ifdef SQRT_ARB_REMAINDER_EN
      rsp_rem_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      id_q         <= id_d;
      x_q          <= x_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_id_q     <= rsp_id_d;
`ifdef SQRT_ARB_REMAINDER_EN
      rsp_rem_q    <= rsp_rem_d;
`endif
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_id_o     = rsp_id_q;
`ifdef SQRT_ARB_REMAINDER_EN
  assign rsp_rem_o    = rsp_rem_q;
`endif
  assign busy_o       = (state_q != IDLE);
endmodule
